fftc2_frame_collector: RTL

- Downstream neighbour of the column-2 butterfly stage.
- Each cycle, the column-2 stage time-multiplexes 4 complex MACs over 4 phases (phase select 0..3), and each MAC produces 2 results per phase.
- This block captures those 8 results per beat into a 32-word frame and hands complete frames to the next column over a valid/ready handshake.
- Ping-pong banked, so a new frame can fill while the previous one is held.

---
 rtl/fftc2_frame_collector.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fftc2_frame_collector.sv
// fftc2_frame_collector: gathers the 8 MAC results per beat from the column-2
// butterfly stage into 32-word frames and hands them downstream over valid/ready.
// Two banks ping-pong so one frame can fill while the other is held.
// Optional in_sel sequence checking is enabled by defining FFTC2_COLLECT_SEQ_CHECK_EN.
module fftc2_frame_collector #(
    parameter int unsigned DW    = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [1:0]         in_sel_i,
    input  logic [8*DW-1:0]    in_data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [32*DW-1:0]   out_frame_o,
    output logic [CNT_W-1:0]   frame_cnt_o,
    output logic               seq_err_o
);

    logic [DW-1:0]    bank_q [2][32];
    logic [1:0]       full_q, full_d;
    logic             wp_q, wp_d;
    logic             rp_q, rp_d;
    logic [1:0]       ph_q, ph_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             seq_err_q, seq_err_d;

    logic             accept;
    logic             handoff;
    logic             wr_en;
    logic [1:0]       wr_ph;

    assign in_ready_o  = !full_q[wp_q];
    assign out_valid_o = full_q[rp_q];
    assign accept      = in_valid_i && in_ready_o;
    assign handoff     = out_valid_o && out_ready_i;
    assign frame_cnt_o = cnt_q;
    assign seq_err_o   = seq_err_q;

`ifdef FFTC2_COLLECT_SEQ_CHECK_EN
    logic seq_match;
    logic restart;

    // Decide whether an accepted beat is written, and at which phase slot.
    always_comb begin
        seq_match = (in_sel_i == ph_q);
        // An out-of-order phase 0 beat starts a fresh frame rather than being lost.
        restart   = !seq_match && (in_sel_i == 2'd0);
        wr_en     = accept && (seq_match || restart);
        wr_ph     = seq_match ? ph_q : 2'd0;
        seq_err_d = accept && !seq_match;
    end
`else
    logic unused_sel;

    // Without checking, beats are placed purely by the local phase counter.
    always_comb begin
        unused_sel = ^in_sel_i;
        wr_en      = accept;
        wr_ph      = ph_q;
        seq_err_d  = 1'b0;
    end
`endif

    // Next-state for bank flags, pointers, phase and frame counter.
    always_comb begin
        full_d = full_q;
        wp_d   = wp_q;
        rp_d   = rp_q;
        ph_d   = ph_q;
        cnt_d  = cnt_q;
        // Handoff and fill completion always target different banks, so both apply.
        if (handoff) begin
            full_d[rp_q] = 1'b0;
            rp_d         = ~rp_q;
            cnt_d        = cnt_q + CNT_W'(1);
        end
        if (wr_en) begin
            if (wr_ph == 2'd3) begin
                full_d[wp_q] = 1'b1;
                wp_d         = ~wp_q;
                ph_d         = 2'd0;
            end else begin
                ph_d = wr_ph + 2'd1;
            end
        end else if (accept) begin
            // Dropped out-of-sequence beat: discard the partial frame.
            ph_d = 2'd0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q    <= 2'b00;
            wp_q      <= 1'b0;
            rp_q      <= 1'b0;
            ph_q      <= 2'd0;
            cnt_q     <= '0;
            seq_err_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            ph_q      <= ph_d;
            cnt_q     <= cnt_d;
            seq_err_q <= seq_err_d;
        end
    end

    // Bank storage: one beat writes all 8 lanes into the fill bank at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int w = 0; w < 32; w++) begin
                    bank_q[b][w] <= '0;
                end
            end
        end else if (wr_en) begin
            for (int m = 0; m < 4; m++) begin
                // Lane 2m -> word 8m+p, lane 2m+1 -> word 8m+4+p.
                bank_q[wp_q][{m[1:0], 1'b0, wr_ph}] <= in_data_i[(2*m)*DW +: DW];
                bank_q[wp_q][{m[1:0], 1'b1, wr_ph}] <= in_data_i[(2*m+1)*DW +: DW];
            end
        end
    end

    // Present the read bank; it cannot change while held because only the fill bank is written.
    always_comb begin
        out_frame_o = '0;
        for (int w = 0; w < 32; w++) begin
            out_frame_o[w*DW +: DW] = bank_q[rp_q][w];
        end
    end

endmodule
